// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer and the control-signal LUT:
// phase codes, opcode nibbles and the NOP encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    OUTPUT    = 3'd4
  } phase_e;

  localparam logic [3:0] OP_JUMP = 4'h9;
  localparam logic [3:0] OP_BEZ  = 4'hE;
  localparam logic [3:0] OP_BNEZ = 4'hF;
  localparam logic [3:0] OP_LOAD = 4'hA;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  // Jumps and branches resolve in EXECUTE and skip WRITEBACK/OUTPUT.
  function automatic logic is_ctrl_xfer(input logic [7:0] instr);
    return (instr[3:0] == OP_JUMP) || (instr[3:0] == OP_BEZ) || (instr[3:0] == OP_BNEZ);
  endfunction

endpackage

// File: rtl/cpu_retire_counter.sv
// Wrapping count of retired instructions; advances when inc and ena are both high.
module cpu_retire_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena && inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction register and phase FSM driving the control LUT's instruction/state
// inputs; shortens NOP, illegal and jump/branch sequences and counts retirements.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         CNT_W    = 8,
  parameter logic [7:0] IR_RESET = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             ctrl_zero,
  input  logic             halt,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [2:0]       state,
  output logic [7:0]       instruction,
  output logic             out_valid,
  output logic             halted,
  output logic             illegal_err,
  output logic [CNT_W-1:0] retired_cnt
);

  phase_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       err_q, err_d;
  logic       retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= IR_RESET;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q & ~clr_err;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (instr_valid && !halt) begin
          ir_d    = instr_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // An all-zero control word marks an opcode the LUT does not know.
        if (ctrl_zero) begin
          err_d   = 1'b1;
          ir_d    = IR_RESET;
          state_d = FETCH;
        end else if (ir_q == NOP_INSTR) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        if (is_ctrl_xfer(ir_q)) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: state_d = OUTPUT;
      OUTPUT: begin
        if (out_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        // Unused codes recover silently without retiring or flagging.
        ir_d    = IR_RESET;
        state_d = FETCH;
      end
    endcase
  end

  cpu_retire_counter #(
    .CNT_W(CNT_W)
  ) u_retire_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .inc  (retire),
    .cnt  (retired_cnt)
  );

  assign state       = state_q;
  assign instruction = ir_q;
  assign illegal_err = err_q;
  assign instr_ready = (state_q == FETCH) && !halt;
  assign halted      = (state_q == FETCH) && halt;
  assign out_valid   = (state_q == OUTPUT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a per-instruction phase-plan model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] instr_in = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       ctrl_zero = 1'b0;
  logic       halt = 1'b0;
  logic       out_ready = 1'b1;
  logic       clr_err = 1'b0;
  logic [2:0] state;
  logic [7:0] instruction;
  logic       out_valid;
  logic       halted;
  logic       illegal_err;
  logic [7:0] retired_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit started = 1'b0;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .instr_in(instr_in),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .ctrl_zero(ctrl_zero),
    .halt(halt), .out_ready(out_ready), .clr_err(clr_err), .state(state),
    .instruction(instruction), .out_valid(out_valid), .halted(halted),
    .illegal_err(illegal_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: each accepted instruction gets a plan of remaining phases
  // (1=DECODE 2=EXECUTE 3=WRITEBACK 4=OUTPUT); an empty plan means FETCH.
  logic [2:0] plan[$];
  logic [7:0] m_ir;
  logic [7:0] m_cnt;
  bit         m_err;

  function automatic logic [2:0] m_phase();
    return (plan.size() == 0) ? 3'd0 : plan[0];
  endfunction

  initial begin
    m_ir = 8'h00; m_cnt = 8'h00; m_err = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        plan.delete(); m_ir = 8'h00; m_cnt = 8'h00; m_err = 1'b0;
      end else if (ena) begin
        m_err = m_err && !clr_err;
        if (plan.size() == 0) begin
          if (instr_valid && !halt) begin
            m_ir = instr_in;
            if (instr_in == 8'h00) plan = '{3'd1};
            else if (instr_in[3:0] == 4'h9 || instr_in[3:0] == 4'hE || instr_in[3:0] == 4'hF)
              plan = '{3'd1, 3'd2};
            else plan = '{3'd1, 3'd2, 3'd3, 3'd4};
          end
        end else if (plan[0] == 3'd1 && ctrl_zero) begin
          m_err = 1'b1; m_ir = 8'h00; plan.delete();
        end else if (plan[0] != 3'd4 || out_ready) begin
          void'(plan.pop_front());
          if (plan.size() == 0) m_cnt = m_cnt + 8'd1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("state", {29'd0, state}, {29'd0, m_phase()});
        chk("instruction", {24'd0, instruction}, {24'd0, m_ir});
        chk("retired_cnt", {24'd0, retired_cnt}, {24'd0, m_cnt});
        chk("illegal_err", {31'd0, illegal_err}, {31'd0, m_err});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_phase() == 3'd4});
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, m_phase() == 3'd0 && !halt});
        chk("halted", {31'd0, halted}, {31'd0, m_phase() == 3'd0 && halt});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] b);
    instr_in = b; instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
    chk("accept_decode", {29'd0, state}, 32'd1);
  endtask

  task automatic expect_seq(input string name, input int n, input logic [2:0] s0,
                            input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] s3);
    logic [2:0] seq[4];
    seq = '{s0, s1, s2, s3};
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(name, {29'd0, state}, {29'd0, seq[i]});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_cnt", {24'd0, retired_cnt}, 32'd0);
    chk("reset_ready", {31'd0, instr_ready}, 32'd1);

    // ALU instruction, full five-phase sequence
    accept(8'h41);
    expect_seq("alu_seq", 3, 3'd2, 3'd3, 3'd4, 3'd0);
    chk("alu_out_valid", {31'd0, out_valid}, 32'd1);
    expect_seq("alu_end", 1, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("alu_cnt", {24'd0, retired_cnt}, 32'd1);

    // Jump then NOP
    accept(8'h09);
    expect_seq("jump_seq", 2, 3'd2, 3'd0, 3'd0, 3'd0);
    accept(8'h00);
    expect_seq("nop_seq", 1, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("jump_nop_cnt", {24'd0, retired_cnt}, 32'd3);

    // Illegal decode, then clear racing a second illegal decode
    accept(8'h41);
    ctrl_zero = 1'b1;
    cyc();
    chk("illegal_state", {29'd0, state}, 32'd0);
    chk("illegal_err", {31'd0, illegal_err}, 32'd1);
    chk("illegal_ir", {24'd0, instruction}, 32'd0);
    chk("illegal_cnt", {24'd0, retired_cnt}, 32'd3);
    ctrl_zero = 1'b0;
    accept(8'h22);
    ctrl_zero = 1'b1; clr_err = 1'b1;
    cyc();
    chk("set_beats_clr", {31'd0, illegal_err}, 32'd1);
    ctrl_zero = 1'b0;
    cyc();
    clr_err = 1'b0;
    chk("clr_err", {31'd0, illegal_err}, 32'd0);

    // Output backpressure with halt raised mid-instruction
    out_ready = 1'b0;
    accept(8'h53);
    expect_seq("bp_seq", 3, 3'd2, 3'd3, 3'd4, 3'd0);
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold_state", {29'd0, state}, 32'd4);
      chk("bp_hold_ir", {24'd0, instruction}, 32'h53);
    end
    out_ready = 1'b1;
    cyc();
    chk("halt_state", {29'd0, state}, 32'd0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_ready", {31'd0, instr_ready}, 32'd0);
    instr_in = 8'h41; instr_valid = 1'b1;
    cyc();
    chk("halt_no_accept", {29'd0, state}, 32'd0);
    instr_valid = 1'b0; halt = 1'b0;
    chk("bp_cnt", {24'd0, retired_cnt}, 32'd4);

    // Clock enable freezes everything in DECODE
    accept(8'h41);
    ena = 1'b0; ctrl_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ena_state", {29'd0, state}, 32'd1);
      chk("ena_ir", {24'd0, instruction}, 32'h41);
      chk("ena_err", {31'd0, illegal_err}, 32'd0);
    end
    ctrl_zero = 1'b0; ena = 1'b1;
    expect_seq("ena_resume", 4, 3'd2, 3'd3, 3'd4, 3'd0);
    chk("ena_cnt", {24'd0, retired_cnt}, 32'd5);

    // Counter wrap via back-to-back NOPs
    instr_in = 8'h00; instr_valid = 1'b1;
    for (int i = 0; i < 1000 && retired_cnt != 8'hFF; i++) cyc();
    chk("cnt_ff", {24'd0, retired_cnt}, 32'hFF);
    cyc(); cyc();
    instr_valid = 1'b0;
    chk("cnt_wrap", {24'd0, retired_cnt}, 32'h00);

    // Asynchronous reset in EXECUTE, with the error flag set
    accept(8'h41);
    ctrl_zero = 1'b1;
    cyc();
    ctrl_zero = 1'b0;
    accept(8'h41);
    cyc();
    chk("pre_rst_exec", {29'd0, state}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", {29'd0, state}, 32'd0);
    chk("async_rst_ir", {24'd0, instruction}, 32'd0);
    chk("async_rst_cnt", {24'd0, retired_cnt}, 32'd0);
    chk("async_rst_err", {31'd0, illegal_err}, 32'd0);
    cyc();
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] pick[7];
      pick = '{8'h00, 8'h09, 8'h0E, 8'h1F, 8'h41, 8'h3A, 8'h00};
      pick[6] = 8'($urandom);
      instr_in    = pick[$urandom_range(0, 6)];
      instr_valid = ($urandom_range(0, 3) != 0);
      ctrl_zero   = ($urandom_range(0, 7) == 0);
      out_ready   = ($urandom_range(0, 1) == 0);
      halt        = ($urandom_range(0, 9) == 0);
      ena         = ($urandom_range(0, 7) != 0);
      clr_err     = ($urandom_range(0, 7) == 0);
      rst_n       = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
